// File: rtl/riscv_wb.sv
// riscv_wb -- RISC-V write-back stage.
//
// Takes the MEM-stage registers, completes the data-memory response, formats
// load data, and presents the register-file write port, the committed
// exception vector and the pipeline-wide stall. A three-state FSM
// (IDLE / WAIT / FLUSH) tracks outstanding data-memory accesses and the
// one-cycle flush that follows any committed exception.
//
// Optional feature (macro RV_WB_DMEM_TIMEOUT_EN): a WAIT-cycle counter turns
// a response that never arrives into an access fault after DMEM_TIMEOUT
// cycles. With the macro undefined the stage waits indefinitely.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   mem_*               MEM-stage pc/instr/bubble/exception/badaddr/result/address
//   dmem_*              data-memory response: ack, read word, err, misaligned, page fault
//   wb_stall            combinational stall for all upstream stages
//   wb_pc, wb_instr     committed PC / instruction
//   wb_bubble           committed slot is empty
//   wb_exception        committed exception vector (bit index = cause code)
//   wb_badaddr          trap value
//   wb_dst, wb_r, wb_we register-file write port

module riscv_wb #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter int              ILEN           = 32,
  parameter int              EXCEPTION_SIZE = 16,
  parameter int              DMEM_TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           mem_pc,
  input  logic [ILEN-1:0]           mem_instr,
  input  logic                      mem_bubble,
  input  logic [EXCEPTION_SIZE-1:0] mem_exception,
  input  logic [XLEN-1:0]           mem_pc_badaddr,
  input  logic [XLEN-1:0]           mem_r,
  input  logic [XLEN-1:0]           mem_memadr,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_err,
  input  logic                      dmem_misaligned,
  input  logic                      dmem_page_fault,
  output logic                      wb_stall,
  output logic [XLEN-1:0]           wb_pc,
  output logic [ILEN-1:0]           wb_instr,
  output logic                      wb_bubble,
  output logic [EXCEPTION_SIZE-1:0] wb_exception,
  output logic [XLEN-1:0]           wb_badaddr,
  output logic [4:0]                wb_dst,
  output logic [XLEN-1:0]           wb_r,
  output logic                      wb_we
);

  localparam int         OFFW     = (XLEN == 64) ? 3 : 2;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]           pc_q, pc_d;
  logic [ILEN-1:0]           instr_q, instr_d;
  logic                      bubble_q, bubble_d;
  logic [EXCEPTION_SIZE-1:0] exception_q, exception_d;
  logic [XLEN-1:0]           badaddr_q, badaddr_d;
  logic [4:0]                dst_q, dst_d;
  logic [XLEN-1:0]           r_q, r_d;
  logic                      we_q, we_d;

  logic [4:0]                opcode, rd;
  logic [2:0]                funct3;
  logic                      is_load, is_store, memop, resp, resp_eff, err_eff;
  logic                      timeout_hit, flush_now, writes_rd;
  logic [EXCEPTION_SIZE-1:0] fault_vec, exc_new;
  logic [XLEN-1:0]           ld_raw, ld_data;

  assign opcode    = mem_instr[6:2];
  assign funct3    = mem_instr[14:12];
  assign rd        = mem_instr[11:7];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign memop     = !mem_bubble && (mem_exception == '0) && (is_load || is_store);
  assign resp      = dmem_ack | dmem_err | dmem_misaligned | dmem_page_fault;
  // A timeout behaves exactly like an err response arriving this cycle.
  assign resp_eff  = resp | timeout_hit;
  assign err_eff   = dmem_err | timeout_hit;
  // wb_exception is nonzero exactly while the FSM sits in FLUSH.
  assign flush_now = (exception_q != '0);
  assign wb_stall  = memop && !resp_eff && (state_q != S_FLUSH);

`ifdef RV_WB_DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter already reads 1 in the first WAIT cycle, so the stall
  // (which includes the IDLE cycle the access appeared in) lasts exactly
  // DMEM_TIMEOUT cycles.
  assign timeout_hit = (state_q == S_WAIT) && !resp && (cnt_q == CNT_W'(DMEM_TIMEOUT));
  assign cnt_d       = (state_d == S_WAIT) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Memory fault decode: misaligned beats page fault beats access fault,
  // and any fault beats ack.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fault_vec = '0;
    if (memop) begin
      if (dmem_misaligned)      fault_vec[is_store ? 6  : 4]  = 1'b1;
      else if (dmem_page_fault) fault_vec[is_store ? 15 : 13] = 1'b1;
      else if (err_eff)         fault_vec[is_store ? 7  : 5]  = 1'b1;
    end
  end

  assign exc_new = mem_exception | fault_vec;

  // Load formatting: shift the addressed byte lane down, then extend.
  always_comb begin
    ld_raw = dmem_q >> {mem_memadr[OFFW-1:0], 3'b000};
    case (funct3)
      3'b000:  ld_data = XLEN'($signed(ld_raw[7:0]));
      3'b001:  ld_data = XLEN'($signed(ld_raw[15:0]));
      3'b010:  ld_data = XLEN'($signed(ld_raw[31:0]));
      3'b100:  ld_data = XLEN'(ld_raw[7:0]);
      3'b101:  ld_data = XLEN'(ld_raw[15:0]);
      3'b110:  ld_data = XLEN'(ld_raw[31:0]);
      default: ld_data = ld_raw;
    endcase
  end

  always_comb begin
    case (opcode)
      5'b00100, 5'b01100, 5'b01101, 5'b00101,
      5'b11011, 5'b11001, 5'b00000:     writes_rd = 1'b1;
      5'b11100:                         writes_rd = (funct3 != 3'b000);
      5'b00110, 5'b01110:               writes_rd = (XLEN == 64);
      default:                          writes_rd = 1'b0;
    endcase
  end

  // Next-state FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (memop && !resp) state_d = S_WAIT;
      S_WAIT:  if (resp_eff || !memop) state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!flush_now && !wb_stall && (exc_new != '0)) state_d = S_FLUSH;
  end

  // Output register update: flush, capture, or hold.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    bubble_d    = bubble_q;
    exception_d = exception_q;
    badaddr_d   = badaddr_q;
    dst_d       = dst_q;
    r_d         = r_q;
    we_d        = we_q;
    if (flush_now) begin
      exception_d = '0;
      bubble_d    = 1'b1;
      we_d        = 1'b0;
    end else if (!wb_stall) begin
      pc_d        = mem_pc;
      instr_d     = mem_instr;
      bubble_d    = mem_bubble;
      dst_d       = rd;
      exception_d = exc_new;
      badaddr_d   = (fault_vec != '0) ? mem_memadr : mem_pc_badaddr;
      r_d         = is_load ? ld_data : mem_r;
      we_d        = !mem_bubble && (exc_new == '0) && (rd != 5'd0) && writes_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= S_IDLE;
      pc_q        <= PC_INIT;
      instr_q     <= '0;
      bubble_q    <= 1'b1;
      exception_q <= '0;
      badaddr_q   <= '0;
      dst_q       <= '0;
      r_q         <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      bubble_q    <= bubble_d;
      exception_q <= exception_d;
      badaddr_q   <= badaddr_d;
      dst_q       <= dst_d;
      r_q         <= r_d;
      we_q        <= we_d;
    end
  end

  assign wb_pc        = pc_q;
  assign wb_instr     = instr_q;
  assign wb_bubble    = bubble_q;
  assign wb_exception = exception_q;
  assign wb_badaddr   = badaddr_q;
  assign wb_dst       = dst_q;
  assign wb_r         = r_q;
  assign wb_we        = we_q;

endmodule

// File: doc/riscv_wb.md
Name: riscv_wb

Overview:
- Write-back stage, directly downstream of the memory stage.
- Consumes the MEM-stage registers (pc, instr, bubble, exception, result, data address) and completes data-memory responses.
- Formats load data and produces the register-file write port, the committed exception vector and the pipeline-wide stall.
- Single registered stage; also owns the wait-for-dmem-response state machine.

Parameters:
- XLEN, 32: datapath width; 32 or 64.
- PC_INIT, 'h200: reset value of wb_pc.
- ILEN, 32: instruction width.
- EXCEPTION_SIZE, 16: exception vector width; bit index = cause code.
- DMEM_TIMEOUT, 255: cycles before a missing response is declared a fault; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_pc  in  XLEN  MEM-stage PC.
- mem_instr  in  ILEN  MEM-stage instruction.
- mem_bubble  in  1  MEM slot empty.
- mem_exception  in  EXCEPTION_SIZE  exceptions raised upstream.
- mem_pc_badaddr  in  XLEN  bad address for upstream exceptions.
- mem_r  in  XLEN  ALU/CSR result.
- mem_memadr  in  XLEN  data address of load/store.
- dmem_ack  in  1  data response valid.
- dmem_q  in  XLEN  raw aligned read word.
- dmem_err  in  1  access fault response.
- dmem_misaligned  in  1  misaligned response.
- dmem_page_fault  in  1  page fault response.
- wb_stall  out  1  combinational; freezes all upstream stages.
- wb_pc  out  XLEN  committed PC.
- wb_instr  out  ILEN  committed instruction.
- wb_bubble  out  1  committed slot empty.
- wb_exception  out  EXCEPTION_SIZE  committed exceptions.
- wb_badaddr  out  XLEN  trap value.
- wb_dst  out  5  destination register, instr[11:7].
- wb_r  out  XLEN  write-back data.
- wb_we  out  1  register-file write enable.

Behaviour:
- Reset values:
  - wb_pc = PC_INIT, wb_bubble = 1.
  - wb_exception, wb_badaddr, wb_r, wb_dst, wb_we all 0.
  - wb_instr is 0 (a NOP encoding is not required).
  - FSM = IDLE, timeout counter = 0.
- Decode, using opcode = instr[6:2]:
  - LOAD = 00000, STORE = 01000.
  - memop = !mem_bubble & ~|mem_exception & (LOAD | STORE).
- Response: resp = dmem_ack | dmem_err | dmem_misaligned | dmem_page_fault.
- Stall: wb_stall = memop & !resp & (state != FLUSH). Combinational; zero extra latency.
- FSM IDLE → WAIT:
  - Taken when memop & !resp.
- FSM WAIT:
  - Holds until resp.
  - On resp: go to FLUSH if any fault bit is set, otherwise go to IDLE.
- FSM FLUSH:
  - Entered whenever wb_exception is nonzero.
  - Lasts exactly one cycle, then returns to IDLE.
- Response priority, highest first: misaligned, then page_fault, then err, then ack.
  - Load causes: misaligned = 4, access fault = 5, page fault = 13.
  - Store causes: misaligned = 6, access fault = 7, page fault = 15.
- Register update, in priority order:
  - If |wb_exception: wb_exception <= 0, wb_bubble <= 1, wb_we <= 0. MEM content is dropped (flush).
  - Else if !wb_stall: capture pc, instr, bubble, dst.
    - wb_exception <= mem_exception | memory-fault bit.
    - wb_badaddr <= mem_memadr on a memory fault, else mem_pc_badaddr.
  - Else: all outputs hold.
- Load formatting:
  - Byte offset = mem_memadr[1:0] (XLEN=32) or [2:0] (XLEN=64).
  - data = dmem_q >> (8·offset).
  - funct3 = instr[14:12]: 000 LB sign-extend, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU zero-extend, 101 LHU, 110 LWU.
  - Non-load instructions: wb_r <= mem_r.
- wb_we <= !mem_bubble & no exception & rd != 0 & opcode writes rd.
  - Opcodes that write rd: 00100, 01100, 01101, 00101, 11011, 11001, 00000, 11100 with funct3 != 0.
  - Also 00110 and 01110 when XLEN=64.
  - STORE never writes.
- Boundary cases:
  - resp in the same cycle memop first appears: no stall, no WAIT entry.
  - ack together with err: the fault wins; no write.
  - Any of resp seen in IDLE without memop: ignored.
  - rst asserted mid-WAIT: immediate return to reset values; a later stray response is ignored.

Optional Feature:
- Macro: RV_WB_DMEM_TIMEOUT_EN.
- Enabled:
  - Counter of width clog2(DMEM_TIMEOUT+1) increments each WAIT cycle and clears outside WAIT.
  - When the counter reaches DMEM_TIMEOUT with no resp, it is treated as dmem_err (cause 5 or 7), stall releases and FSM → FLUSH.
- Disabled: counter absent; WAIT lasts indefinitely.

Test Plan:
- LW at 0x1004, ack after 3 cycles with dmem_q = 0xDEADBEEF → wb_stall high for 3 cycles; then wb_r = 0xDEADBEEF, wb_we = 1, wb_dst = rd.
- LB at 0x1003 with dmem_q = 0x80112233 → wb_r = 0xFFFFFF80. LBU at the same address → wb_r = 0x00000080.
- SW with dmem_misaligned = 1 and dmem_ack = 1 in the same cycle → wb_exception bit 6 set, wb_badaddr = mem_memadr, wb_we = 0. Next cycle wb_exception = 0 and wb_bubble = 1.
- ADD with rd = x0, mem_r = 5 → wb_we = 0. ADD with rd = x3 → wb_we = 1, wb_r = 5, one-cycle latency.
- rst pulse while in WAIT → next cycle wb_pc = 0x200, wb_bubble = 1, wb_stall = 0. A following dmem_ack has no effect.
- RV_WB_DMEM_TIMEOUT_EN with DMEM_TIMEOUT = 4, LW and no response → stall releases after 4 cycles, wb_exception bit 5 set.
